digital_lock_ctrl: RTL and testbench

//  Parametrised keypad lock controller. Collects a multi-digit code, compares it with a stored code,

---
 rtl/digital_lock_pkg.sv | 20 ++
 rtl/lock_timer.sv | 27 ++
 rtl/digital_lock_ctrl.sv | 195 +++++++++++++++++++
 tb/tb_digital_lock_ctrl.sv | 311 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/digital_lock_pkg.sv
// Shared types and helpers for the keypad lock controller and its timer.
package digital_lock_pkg;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_ENTRY = 3'd1,
        ST_CHECK = 3'd2,
        ST_OPEN  = 3'd3,
        ST_PROG  = 3'd4,
        ST_ALARM = 3'd5
    } state_t;

    localparam int DIGIT_MAX = 9;

    // Width of a down-counter able to hold the larger of two cycle counts.
    function automatic int timer_w(input int a, input int b);
        return $clog2(((a > b) ? a : b) + 1);
    endfunction

endpackage

// File: rtl/lock_timer.sv
// Loadable down-counter; expired is high on the cycle the count reads 1.
module lock_timer #(
    parameter int W = 8
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         load,
    input  logic [W-1:0] load_val,
    input  logic         en,
    output logic         expired
);

    logic [W-1:0] r_cnt;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_cnt <= '0;
        end else if (load) begin
            r_cnt <= load_val;
        end else if (en && (r_cnt != '0)) begin
            r_cnt <= r_cnt - 1'b1;
        end
    end

    assign expired = (r_cnt == W'(1));

endmodule

// File: rtl/digital_lock_ctrl.sv
// Keypad lock controller: code entry and compare, fail counting with timed alarm,
// auto-relocking open state and in-field code reprogramming.
module digital_lock_ctrl
    import digital_lock_pkg::*;
#(
    parameter int                            DIGIT_W      = 4,
    parameter int                            N_DIGITS     = 4,
    parameter logic [DIGIT_W*N_DIGITS-1:0]   DEFAULT_CODE = 16'h1234,
    parameter int                            MAX_TRIES    = 3,
    parameter int                            OPEN_CYC     = 1000,
    parameter int                            LOCK_CYC     = 5000
) (
    input  logic                             clk,
    input  logic                             rst_n,
    input  logic                             digit_valid,
    input  logic [DIGIT_W-1:0]               digit,
    input  logic                             enter,
    input  logic                             clear,
    input  logic                             relock,
    input  logic                             prog_en,
    output logic                             unlock,
    output logic                             alarm,
    output logic                             done,
    output logic                             prog_ok,
    output logic [$clog2(MAX_TRIES+1)-1:0]   fail_cnt,
    output logic                             busy
);

    localparam int EW = DIGIT_W * N_DIGITS;
    localparam int CW = $clog2(N_DIGITS + 2);
    localparam int FW = $clog2(MAX_TRIES + 1);
    localparam int TW = timer_w(OPEN_CYC, LOCK_CYC);

    state_t          r_state;
    logic [EW-1:0]   r_entry;
    logic [CW-1:0]   r_cnt;
    logic            r_bad;
    logic [EW-1:0]   r_code;
    logic [FW-1:0]   r_fail;
    logic            r_unlock;
    logic            r_alarm;
    logic            r_done;
    logic            r_prog_ok;
    logic            r_busy;

    logic            w_entry_good;
    logic            w_match;
    logic [FW-1:0]   w_fail_inc;
    logic            w_alarm_next;
    logic            w_digit_bad;
    logic [EW-1:0]   w_entry_shift;
    logic [CW-1:0]   w_cnt_inc;
    logic            w_tmr_load;
    logic [TW-1:0]   w_tmr_val;
    logic            w_tmr_exp;

    assign w_entry_good  = (r_cnt == CW'(N_DIGITS)) && !r_bad;
    assign w_match       = w_entry_good && (r_entry == r_code);
    assign w_fail_inc    = (r_fail == FW'(MAX_TRIES)) ? r_fail : r_fail + 1'b1;
    assign w_alarm_next  = (w_fail_inc == FW'(MAX_TRIES));
    // A digit that would overflow the code length poisons the entry for good.
    assign w_digit_bad   = (digit > DIGIT_W'(DIGIT_MAX)) || (r_cnt >= CW'(N_DIGITS));
    assign w_entry_shift = (r_entry << DIGIT_W) | EW'(digit);
    assign w_cnt_inc     = (r_cnt == CW'(N_DIGITS + 1)) ? r_cnt : r_cnt + 1'b1;

    // Timer is reloaded on every entry into OPEN, PROG or ALARM and on each PROG digit.
    always_comb begin
        w_tmr_load = 1'b0;
        w_tmr_val  = TW'(OPEN_CYC);
        case (r_state)
            ST_CHECK: begin
                w_tmr_load = 1'b1;
                if (!w_match) w_tmr_val = TW'(LOCK_CYC);
            end
            ST_OPEN:  w_tmr_load = prog_en;
            ST_PROG:  w_tmr_load = clear | enter | digit_valid | w_tmr_exp;
            default:  w_tmr_load = 1'b0;
        endcase
    end

    lock_timer #(
        .W(TW)
    ) u_timer (
        .clk      (clk),
        .rst_n    (rst_n),
        .load     (w_tmr_load),
        .load_val (w_tmr_val),
        .en       (1'b1),
        .expired  (w_tmr_exp)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state   <= ST_IDLE;
            r_entry   <= '0;
            r_cnt     <= '0;
            r_bad     <= 1'b0;
            r_code    <= DEFAULT_CODE;
            r_fail    <= '0;
            r_unlock  <= 1'b0;
            r_alarm   <= 1'b0;
            r_done    <= 1'b0;
            r_prog_ok <= 1'b0;
            r_busy    <= 1'b0;
        end else begin
            r_done    <= 1'b0;
            r_prog_ok <= 1'b0;
            case (r_state)
                ST_IDLE, ST_ENTRY: begin
                    if (clear) begin
                        r_entry <= '0;
                        r_cnt   <= '0;
                        r_bad   <= 1'b0;
                        r_state <= ST_IDLE;
                    end else if (enter) begin
                        r_state <= ST_CHECK;
                        r_busy  <= 1'b1;
                    end else if (digit_valid) begin
                        r_entry <= w_entry_shift;
                        r_cnt   <= w_cnt_inc;
                        if (w_digit_bad) r_bad <= 1'b1;
                        r_state <= ST_ENTRY;
                    end
                end
                ST_CHECK: begin
                    r_entry <= '0;
                    r_cnt   <= '0;
                    r_bad   <= 1'b0;
                    r_done  <= 1'b1;
                    if (w_match) begin
                        r_state  <= ST_OPEN;
                        r_unlock <= 1'b1;
                        r_fail   <= '0;
                    end else begin
                        r_fail <= w_fail_inc;
                        if (w_alarm_next) begin
                            r_state <= ST_ALARM;
                            r_alarm <= 1'b1;
                        end else begin
                            r_state <= ST_IDLE;
                            r_busy  <= 1'b0;
                        end
                    end
                end
                ST_OPEN: begin
                    if (prog_en) begin
                        r_state <= ST_PROG;
                    end else if (relock || w_tmr_exp) begin
                        r_state  <= ST_IDLE;
                        r_unlock <= 1'b0;
                        r_busy   <= 1'b0;
                    end
                end
                ST_PROG: begin
                    if (clear || w_tmr_exp || enter) begin
                        if (enter && !clear && !w_tmr_exp && w_entry_good) begin
                            r_code    <= r_entry;
                            r_prog_ok <= 1'b1;
                        end
                        r_entry <= '0;
                        r_cnt   <= '0;
                        r_bad   <= 1'b0;
                        r_state <= ST_OPEN;
                    end else if (digit_valid) begin
                        r_entry <= w_entry_shift;
                        r_cnt   <= w_cnt_inc;
                        if (w_digit_bad) r_bad <= 1'b1;
                    end
                end
                ST_ALARM: begin
                    if (w_tmr_exp) begin
                        r_state <= ST_IDLE;
                        r_alarm <= 1'b0;
                        r_fail  <= '0;
                        r_busy  <= 1'b0;
                    end
                end
                default: begin
                    r_state  <= ST_IDLE;
                    r_unlock <= 1'b0;
                    r_alarm  <= 1'b0;
                    r_busy   <= 1'b0;
                end
            endcase
        end
    end

    assign unlock   = r_unlock;
    assign alarm    = r_alarm;
    assign done     = r_done;
    assign prog_ok  = r_prog_ok;
    assign fail_cnt = r_fail;
    assign busy     = r_busy;

endmodule

// File: tb/tb_digital_lock_ctrl.sv
// Bench for digital_lock_ctrl: directed key sequences checked every cycle against
// an abstract model of the lock (digit queue, remaining-cycle counts), plus literal checks.
module tb_digital_lock_ctrl;

    localparam int OPEN = 8;
    localparam int LOCK = 16;
    localparam int ND   = 4;
    localparam int MAXT = 3;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       digit_valid = 1'b0;
    logic [3:0] digit = 4'd0;
    logic       enter = 1'b0;
    logic       clear = 1'b0;
    logic       relock = 1'b0;
    logic       prog_en = 1'b0;
    logic       unlock, alarm, done, prog_ok, busy;
    logic [1:0] fail_cnt;

    int n_total = 0;
    int n_bad = 0;

    digital_lock_ctrl #(
        .OPEN_CYC(OPEN),
        .LOCK_CYC(LOCK)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .digit_valid (digit_valid),
        .digit       (digit),
        .enter       (enter),
        .clear       (clear),
        .relock      (relock),
        .prog_en     (prog_en),
        .unlock      (unlock),
        .alarm       (alarm),
        .done        (done),
        .prog_ok     (prog_ok),
        .fail_cnt    (fail_cnt),
        .busy        (busy)
    );

    always #5 clk = ~clk;

    // Model: what the lock is doing, expressed as remaining cycles per activity.
    int q[$];
    int mcode[ND] = '{1, 2, 3, 4};
    bit m_pending = 0, m_prog = 0, m_done = 0, m_prog_ok = 0;
    int m_open_left = 0, m_prog_left = 0, m_alarm_left = 0, m_fails = 0;

    task automatic model_reset();
        q.delete();
        mcode = '{1, 2, 3, 4};
        m_pending = 0; m_prog = 0; m_done = 0; m_prog_ok = 0;
        m_open_left = 0; m_prog_left = 0; m_alarm_left = 0; m_fails = 0;
    endtask

    function automatic bit entry_good();
        if (q.size() != ND) return 0;
        foreach (q[i]) if (q[i] > 9) return 0;
        return 1;
    endfunction

    function automatic bit entry_matches();
        if (!entry_good()) return 0;
        foreach (q[i]) if (q[i] != mcode[i]) return 0;
        return 1;
    endfunction

    task automatic model_step();
        if (!rst_n) begin
            model_reset();
            return;
        end
        m_done = 0;
        m_prog_ok = 0;
        if (m_alarm_left > 0) begin
            m_alarm_left--;
            if (m_alarm_left == 0) m_fails = 0;
        end else if (m_pending) begin
            m_pending = 0;
            m_done = 1;
            if (entry_matches()) begin
                m_open_left = OPEN;
                m_fails = 0;
            end else begin
                m_fails = (m_fails + 1 > MAXT) ? MAXT : m_fails + 1;
                if (m_fails == MAXT) m_alarm_left = LOCK;
            end
            q.delete();
        end else if (m_prog) begin
            if (clear || m_prog_left == 1) begin
                m_prog = 0; m_open_left = OPEN; q.delete();
            end else if (enter) begin
                if (entry_good()) begin
                    foreach (mcode[i]) mcode[i] = q[i];
                    m_prog_ok = 1;
                end
                m_prog = 0; m_open_left = OPEN; q.delete();
            end else if (digit_valid) begin
                q.push_back(int'(digit));
                m_prog_left = OPEN;
            end else begin
                m_prog_left--;
            end
        end else if (m_open_left > 0) begin
            if (prog_en) begin
                m_prog = 1; m_prog_left = OPEN; m_open_left = 0;
            end else if (relock || m_open_left == 1) begin
                m_open_left = 0;
            end else begin
                m_open_left--;
            end
        end else begin
            if (clear) q.delete();
            else if (enter) m_pending = 1;
            else if (digit_valid) q.push_back(int'(digit));
        end
    endtask

    initial forever begin
        @(posedge clk);
        model_step();
    end

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0d want %0d at %0t", nm, act, exp, $time);
        end
    endtask

    initial forever begin
        @(negedge clk);
        chk("m_unlock",  32'(unlock),   32'((m_open_left > 0) || m_prog));
        chk("m_alarm",   32'(alarm),    32'(m_alarm_left > 0));
        chk("m_done",    32'(done),     32'(m_done));
        chk("m_prog_ok", 32'(prog_ok),  32'(m_prog_ok));
        chk("m_fail",    32'(fail_cnt), 32'(m_fails));
        chk("m_busy",    32'(busy),     32'(m_pending || m_prog || m_open_left > 0 || m_alarm_left > 0));
    end

    // Inputs change just after the falling edge so both edges see them stable.
    task automatic step();
        @(negedge clk);
        #1;
    endtask

    task automatic idle(input int n);
        repeat (n) step();
    endtask

    task automatic press(input bit dv, input int d, input bit en, input bit cl, input bit rl, input bit pe);
        digit_valid = dv; digit = 4'(d); enter = en; clear = cl; relock = rl; prog_en = pe;
        step();
        digit_valid = 0; digit = 4'd0; enter = 0; clear = 0; relock = 0; prog_en = 0;
    endtask

    task automatic key(input int d);
        press(1, d, 0, 0, 0, 0);
    endtask

    task automatic send4(input int a, input int b, input int c, input int d);
        key(a); key(b); key(c); key(d);
        press(0, 0, 1, 0, 0, 0);
    endtask

    task automatic do_reset();
        rst_n = 0;
        step();
        chk("rst_unlock", 32'(unlock), 0);
        chk("rst_alarm",  32'(alarm), 0);
        chk("rst_fail",   32'(fail_cnt), 0);
        chk("rst_busy",   32'(busy), 0);
        rst_n = 1;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout want finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        idle(3);
        chk("reset_unlock", 32'(unlock), 0);
        chk("reset_done",   32'(done), 0);
        chk("reset_busy",   32'(busy), 0);
        rst_n = 1;

        // correct code unlocks two edges after enter, relocks after OPEN cycles
        send4(1, 2, 3, 4);
        chk("t1_busy_check", 32'(busy), 1);
        chk("t1_done_early", 32'(done), 0);
        idle(1);
        chk("t1_done", 32'(done), 1);
        chk("t1_unlock", 32'(unlock), 1);
        idle(7);
        chk("t1_unlock_last", 32'(unlock), 1);
        idle(1);
        chk("t1_relocked", 32'(unlock), 0);

        // three wrong codes raise the alarm, keys ignored during lockout
        for (int i = 0; i < 3; i++) begin
            send4(1, 2, 3, 5);
            idle(1);
            chk("t2_done", 32'(done), 1);
            chk("t2_fail", 32'(fail_cnt), 32'(i + 1));
        end
        chk("t2_alarm_on", 32'(alarm), 1);
        send4(1, 2, 3, 4);
        idle(10);
        chk("t2_alarm_hold", 32'(alarm), 1);
        chk("t2_unlock_off", 32'(unlock), 0);
        idle(1);
        chk("t2_alarm_off", 32'(alarm), 0);
        chk("t2_fail_clr", 32'(fail_cnt), 0);

        // short, long and non-decimal entries are failures
        key(1); key(2); key(3); press(0, 0, 1, 0, 0, 0);
        idle(1);
        chk("t3_short", 32'(fail_cnt), 1);
        key(1); key(2); key(3); key(4); key(4); press(0, 0, 1, 0, 0, 0);
        idle(1);
        chk("t3_long", 32'(fail_cnt), 2);
        send4(1, 2, 'hA, 4);
        idle(1);
        chk("t3_hex", 32'(fail_cnt), 3);
        chk("t3_alarm", 32'(alarm), 1);
        idle(16);
        chk("t3_alarm_off", 32'(alarm), 0);

        // reprogramming
        send4(1, 2, 3, 4);
        idle(1);
        press(0, 0, 0, 0, 0, 1);
        chk("t4_prog_unlock", 32'(unlock), 1);
        key(9); key(8); key(7); press(0, 0, 1, 0, 0, 0);
        chk("t4_short_no_ok", 32'(prog_ok), 0);
        press(0, 0, 0, 0, 0, 1);
        send4(9, 8, 7, 6);
        chk("t4_prog_ok", 32'(prog_ok), 1);
        press(0, 0, 0, 0, 1, 0);
        chk("t4_relock", 32'(unlock), 0);
        send4(1, 2, 3, 4);
        idle(1);
        chk("t4_old_fails", 32'(fail_cnt), 1);
        chk("t4_old_locked", 32'(unlock), 0);
        send4(9, 8, 7, 6);
        idle(1);
        chk("t4_new_opens", 32'(unlock), 1);
        chk("t4_fail_clr", 32'(fail_cnt), 0);
        press(0, 0, 0, 0, 0, 1);
        idle(15);
        chk("t4_prog_timeout_open", 32'(unlock), 1);
        idle(1);
        chk("t4_open_timeout", 32'(unlock), 0);

        // same-cycle priorities
        key(9); key(8);
        press(0, 0, 1, 1, 0, 0);
        idle(1);
        chk("t5_clear_wins_done", 32'(done), 0);
        chk("t5_clear_wins_busy", 32'(busy), 0);
        key(9); key(8); key(7);
        press(1, 6, 1, 0, 0, 0);
        idle(1);
        chk("t5_digit_dropped", 32'(fail_cnt), 1);
        send4(9, 8, 7, 6);
        idle(1);
        press(0, 0, 0, 0, 1, 1);
        chk("t5_prog_over_relock", 32'(unlock), 1);
        send4(1, 2, 3, 4);
        chk("t5_prog_commit", 32'(prog_ok), 1);
        press(0, 0, 0, 0, 1, 0);

        // reset mid-PROG loses a programmed code
        send4(1, 2, 3, 4);
        idle(1);
        press(0, 0, 0, 0, 0, 1);
        send4(5, 5, 5, 5);
        chk("t6_prog_5555", 32'(prog_ok), 1);
        press(0, 0, 0, 0, 0, 1);
        key(1);
        do_reset();
        send4(1, 2, 3, 4);
        idle(1);
        chk("t6_default_after_prog_rst", 32'(unlock), 1);
        press(0, 0, 0, 0, 1, 0);

        // reset mid-ALARM
        for (int i = 0; i < 3; i++) begin
            send4(0, 0, 0, 0);
            idle(1);
        end
        chk("t6_alarm", 32'(alarm), 1);
        idle(3);
        do_reset();
        send4(1, 2, 3, 4);
        idle(1);
        chk("t6_default_after_alarm_rst", 32'(unlock), 1);
        press(0, 0, 0, 0, 1, 0);
        idle(2);

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

endmodule
